// File: rtl/serial_eeprom_slave.sv
// Two-wire serial EEPROM slave with page writes, sequential reads, write protect,
// and a host-side port for loading and dumping the save memory.
module serial_eeprom_slave #(
    parameter int         ADDR_WIDTH = 13,
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         PAGE_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl,
    input  logic                  sda_in,
    output logic                  sda_out,
    input  logic                  wp,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic                  host_we,
    input  logic [7:0]            host_wdata,
    output logic [7:0]            host_rdata,
    output logic                  dirty,
    input  logic                  dirty_clr
);

    typedef enum logic [2:0] {
        IDLE, DEVSEL, ADDR_HI, ADDR_LO, WRITE, READ, WAIT_STOP
    } state_t;

    state_t                  state;
    logic                    scl_q, sda_q;
    logic [3:0]              bit_cnt;
    logic [7:0]              shift;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [7:0]              rd_data;
    logic                    ack_q, mack_q;
    logic                    ack_c;
    logic                    ser_we;
    logic                    scl_rise, scl_fall, start_c, stop_c;
    logic [7:0]              mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        scl_q <= scl;
        sda_q <= sda_in;
    end

    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start_c  = scl & scl_q & sda_q & ~sda_in;
    assign stop_c   = scl & scl_q & ~sda_q & sda_in;

    always_comb begin
        ack_c = 1'b0;
        case (state)
            DEVSEL:           ack_c = (shift[7:1] == DEV_ADDR);
            ADDR_HI, ADDR_LO: ack_c = 1'b1;
            WRITE:            ack_c = ~wp;
            default:          ack_c = 1'b0;
        endcase
    end

    assign ser_we = (state == WRITE) && scl_fall && (bit_cnt == 4'd9) && ack_q && !reset;

    // Serial write is issued after the host write so it wins an address collision.
    always_ff @(posedge clk) begin
        rd_data    <= mem[ptr];
        host_rdata <= mem[host_addr];
        if (host_we)
            mem[host_addr] <= host_wdata;
        if (ser_we)
            mem[ptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sda_out <= 1'b1;
            dirty   <= 1'b0;
            bit_cnt <= '0;
            shift   <= '0;
            ptr     <= '0;
            ack_q   <= 1'b0;
            mack_q  <= 1'b1;
        end else begin
            if (ser_we)
                dirty <= 1'b1;
            else if (dirty_clr)
                dirty <= 1'b0;

            if (start_c) begin
                state   <= DEVSEL;
                bit_cnt <= '0;
                shift   <= '0;
                sda_out <= 1'b1;
            end else if (stop_c) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sda_out <= 1'b1;
            end else begin
                case (state)
                    DEVSEL, ADDR_HI, ADDR_LO, WRITE: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift   <= {shift[6:0], sda_in};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_rise && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd9;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            ack_q   <= ack_c;
                            sda_out <= ~ack_c;
                        end else if (scl_fall && bit_cnt == 4'd9) begin
                            sda_out <= 1'b1;
                            bit_cnt <= '0;
                            case (state)
                                DEVSEL: begin
                                    if (!ack_q) begin
                                        state <= WAIT_STOP;
                                    end else if (shift[0]) begin
                                        state   <= READ;
                                        shift   <= rd_data;
                                        sda_out <= rd_data[7];
                                        ptr     <= ptr + 1'b1;
                                    end else begin
                                        state <= ADDR_HI;
                                    end
                                end
                                ADDR_HI: begin
                                    ptr[ADDR_WIDTH-1:8] <= shift[ADDR_WIDTH-9:0];
                                    state <= ADDR_LO;
                                end
                                ADDR_LO: begin
                                    ptr[7:0] <= shift;
                                    state    <= WRITE;
                                end
                                default: begin
                                    if (ack_q)
                                        ptr[PAGE_BITS-1:0] <= ptr[PAGE_BITS-1:0] + 1'b1;
                                end
                            endcase
                        end
                    end
                    READ: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_rise && bit_cnt == 4'd8) begin
                            mack_q  <= sda_in;
                            bit_cnt <= 4'd9;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_out <= 1'b1;
                        end else if (scl_fall && bit_cnt == 4'd9) begin
                            bit_cnt <= '0;
                            if (!mack_q) begin
                                shift   <= rd_data;
                                sda_out <= rd_data[7];
                                ptr     <= ptr + 1'b1;
                            end else begin
                                sda_out <= 1'b1;
                                state   <= WAIT_STOP;
                            end
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            shift   <= {shift[6:0], 1'b0};
                            sda_out <= shift[6];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_eeprom_slave.sv
// Directed bench for serial_eeprom_slave: page write, random read, bad device
// select, write protect, host port and reset in the middle of a read.
module tb_serial_eeprom_slave;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset, scl, sda_in, sda_out, wp, host_we, dirty, dirty_clr;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata, host_rdata;

    int errors = 0;
    int checks = 0;

    serial_eeprom_slave #(.ADDR_WIDTH(AW), .DEV_ADDR(7'h50), .PAGE_BITS(5)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_in), .sda_out(sda_out),
        .wp(wp), .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .dirty(dirty), .dirty_clr(dirty_clr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_in = 1'b1; tick(2);
        scl = 1'b1;    tick(3);
        sda_in = 1'b0; tick(3);
        scl = 1'b0;    tick(2);
    endtask

    task automatic bus_stop();
        sda_in = 1'b0; tick(2);
        scl = 1'b1;    tick(3);
        sda_in = 1'b1; tick(3);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_in = b[i]; tick(2);
            scl = 1'b1;    tick(3);
            scl = 1'b0;    tick(1);
        end
        sda_in = 1'b1; tick(2);
        scl = 1'b1;    tick(2);
        ack = ~sda_out;
        tick(1);
        scl = 1'b0;    tick(2);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            tick(2);
            scl = 1'b1; tick(2);
            b = {b[6:0], sda_out};
            tick(1);
            scl = 1'b0;
        end
        tick(1);
        sda_in = mack; tick(1);
        scl = 1'b1;    tick(3);
        scl = 1'b0;    tick(2);
        sda_in = 1'b1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [7:0] d);
        host_addr = a;
        tick(1);
        d = host_rdata;
    endtask

    task automatic test_reset();
        reset = 1'b1; scl = 1'b1; sda_in = 1'b1; wp = 1'b0;
        host_we = 1'b0; dirty_clr = 1'b0; host_addr = '0; host_wdata = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
        checks++;
        if (sda_out !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1", sda_out); end
        checks++;
        if (dirty !== 1'b0) begin errors++; $display("FAIL reset_dirty: got %b expected 0", dirty); end
    endtask

    task automatic test_page_write();
        logic       ack;
        logic [7:0] d;
        logic [7:0] bytes [7];
        logic [AW-1:0] addrs [4];
        logic [7:0]    exp   [4];
        bytes = '{8'hA0, 8'h00, 8'h3E, 8'h11, 8'h22, 8'h33, 8'h44};
        addrs = '{13'h003E, 13'h003F, 13'h0020, 13'h0021};
        exp   = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus_start();
        for (int i = 0; i < 7; i++) begin
            send_byte(bytes[i], ack);
            checks++;
            if (ack !== 1'b1) begin errors++; $display("FAIL page_ack[%0d]: got %b expected 1", i, ack); end
        end
        bus_stop();
        for (int i = 0; i < 4; i++) begin
            host_read(addrs[i], d);
            checks++;
            if (d !== exp[i]) begin errors++; $display("FAIL page_mem[%h]: got %h expected %h", addrs[i], d, exp[i]); end
        end
        checks++;
        if (dirty !== 1'b1) begin errors++; $display("FAIL page_dirty: got %b expected 1", dirty); end
    endtask

    task automatic test_host();
        logic [7:0] d;
        host_write(13'h0123, 8'h5A);
        host_read(13'h0123, d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL host_rd: got %h expected 5a", d); end
        host_addr = 13'h0123; host_wdata = 8'hA5; host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
        checks++;
        if (host_rdata !== 8'h5A) begin errors++; $display("FAIL host_rbw: got %h expected 5a", host_rdata); end
        tick(1);
        checks++;
        if (host_rdata !== 8'hA5) begin errors++; $display("FAIL host_new: got %h expected a5", host_rdata); end
        dirty_clr = 1'b1; tick(1); dirty_clr = 1'b0;
        checks++;
        if (dirty !== 1'b0) begin errors++; $display("FAIL dirty_clr: got %b expected 0", dirty); end
    endtask

    task automatic test_random_read();
        logic       ack;
        logic [7:0] d;
        logic [7:0] hdr [3];
        logic [7:0] exp [3];
        hdr = '{8'hA0, 8'h1F, 8'hFF};
        exp = '{8'hAA, 8'hBB, 8'hCC};
        host_write(13'h1FFF, 8'hAA);
        host_write(13'h0000, 8'hBB);
        host_write(13'h0001, 8'hCC);
        bus_start();
        for (int i = 0; i < 3; i++) begin
            send_byte(hdr[i], ack);
            checks++;
            if (ack !== 1'b1) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected 1", i, ack); end
        end
        bus_start();
        send_byte(8'hA1, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL rr_ack_rd: got %b expected 1", ack); end
        for (int i = 0; i < 3; i++) begin
            recv_byte((i == 2) ? 1'b1 : 1'b0, d);
            checks++;
            if (d !== exp[i]) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", i, d, exp[i]); end
        end
        checks++;
        if (sda_out !== 1'b1) begin errors++; $display("FAIL rr_release: got %b expected 1", sda_out); end
        bus_stop();
    endtask

    task automatic test_bad_devsel();
        logic ack;
        bus_start();
        send_byte(8'hA2, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL bad_dev_ack: got %b expected 0", ack); end
        send_byte(8'h00, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL bad_dev_next: got %b expected 0", ack); end
        checks++;
        if (sda_out !== 1'b1) begin errors++; $display("FAIL bad_dev_sda: got %b expected 1", sda_out); end
        bus_stop();
    endtask

    task automatic test_wp();
        logic       ack;
        logic [7:0] d;
        logic [7:0] bytes [4];
        logic       exp_ack [4];
        bytes   = '{8'hA0, 8'h00, 8'h10, 8'h55};
        exp_ack = '{1'b1, 1'b1, 1'b1, 1'b0};
        host_write(13'h0010, 8'hE1);
        wp = 1'b1;
        bus_start();
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i], ack);
            checks++;
            if (ack !== exp_ack[i]) begin errors++; $display("FAIL wp_ack[%0d]: got %b expected %b", i, ack, exp_ack[i]); end
        end
        bus_stop();
        wp = 1'b0;
        host_read(13'h0010, d);
        checks++;
        if (d !== 8'hE1) begin errors++; $display("FAIL wp_mem: got %h expected e1", d); end
        checks++;
        if (dirty !== 1'b0) begin errors++; $display("FAIL wp_dirty: got %b expected 0", dirty); end
    endtask

    task automatic test_reset_mid_read();
        logic       ack;
        logic [7:0] d;
        // Current-address read of 0x0010 (E1): the 4th bit driven is a 0.
        bus_start();
        send_byte(8'hA1, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL mid_ack: got %b expected 1", ack); end
        for (int i = 0; i < 3; i++) begin
            tick(2); scl = 1'b1; tick(3); scl = 1'b0; tick(1);
        end
        tick(2); scl = 1'b1; tick(2);
        checks++;
        if (sda_out !== 1'b0) begin errors++; $display("FAIL mid_bit4: got %b expected 0", sda_out); end
        reset = 1'b1; tick(1); reset = 1'b0;
        checks++;
        if (sda_out !== 1'b1) begin errors++; $display("FAIL mid_reset_sda: got %b expected 1", sda_out); end
        scl = 1'b0; tick(2);
        bus_start();
        send_byte(8'hA1, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL post_reset_ack: got %b expected 1", ack); end
        recv_byte(1'b1, d);
        checks++;
        if (d !== 8'hBB) begin errors++; $display("FAIL post_reset_data: got %h expected bb", d); end
        bus_stop();
    endtask

    initial begin
        test_reset();
        test_page_write();
        test_host();
        test_random_read();
        test_bad_devsel();
        test_wp();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
